// File: rtl/smol_alu_arbiter_if.sv
// rtl/smol_alu_arbiter_if.sv - request/response/ALU bundle for smol_alu_arbiter (stats ports under SMOL_ALU_ARB_STATS_EN)
interface smol_alu_arbiter_if #(
    parameter int XLEN = 32,
    parameter int OPW  = 5,
    parameter int PCW  = 5
);
    logic            req0_valid;
    logic            req0_ready;
    logic [OPW-1:0]  req0_op;
    logic [XLEN-1:0] req0_a;
    logic [XLEN-1:0] req0_b;
    logic [PCW-1:0]  req0_pc;
    logic            req1_valid;
    logic            req1_ready;
    logic [OPW-1:0]  req1_op;
    logic [XLEN-1:0] req1_a;
    logic [XLEN-1:0] req1_b;
    logic [PCW-1:0]  req1_pc;
    logic            rsp0_valid;
    logic            rsp0_ready;
    logic            rsp1_valid;
    logic            rsp1_ready;
    logic [XLEN-1:0] rsp_data;
    logic [XLEN-1:0] alu_rs1;
    logic [XLEN-1:0] alu_rs2_or_imm;
    logic [PCW-1:0]  alu_pc;
    logic [OPW-1:0]  alu_op_sel;
    logic [XLEN-1:0] alu_out;
`ifdef SMOL_ALU_ARB_STATS_EN
    logic [31:0]     stat_grant0;
    logic [31:0]     stat_grant1;
    logic [31:0]     stat_conflict;

    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_pc,
        input  req1_valid, req1_op, req1_a, req1_b, req1_pc,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_rs1, alu_rs2_or_imm, alu_pc, alu_op_sel,
        output stat_grant0, stat_grant1, stat_conflict
    );
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_pc,
        output req1_valid, req1_op, req1_a, req1_b, req1_pc,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_rs1, alu_rs2_or_imm, alu_pc, alu_op_sel,
        input  stat_grant0, stat_grant1, stat_conflict
    );
`else
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b, req0_pc,
        input  req1_valid, req1_op, req1_a, req1_b, req1_pc,
        input  rsp0_ready, rsp1_ready, alu_out,
        output req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        output alu_rs1, alu_rs2_or_imm, alu_pc, alu_op_sel
    );
    modport master (
        output req0_valid, req0_op, req0_a, req0_b, req0_pc,
        output req1_valid, req1_op, req1_a, req1_b, req1_pc,
        output rsp0_ready, rsp1_ready, alu_out,
        input  req0_ready, req1_ready, rsp0_valid, rsp1_valid, rsp_data,
        input  alu_rs1, alu_rs2_or_imm, alu_pc, alu_op_sel
    );
`endif
endinterface

// File: rtl/smol_alu_arbiter.sv
// rtl/smol_alu_arbiter.sv - round-robin two-port arbiter for the shared smolALU (optional counters: SMOL_ALU_ARB_STATS_EN)
module smol_alu_arbiter #(
    parameter int XLEN = 32,
    parameter int OPW  = 5,
    parameter int PCW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    smol_alu_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    state_t          state;
    logic            prio;
    logic            owner;
    logic            grant;
    logic            accept;
    logic [OPW-1:0]  sel_op;
    logic [XLEN-1:0] sel_a;
    logic [XLEN-1:0] sel_b;
    logic [PCW-1:0]  sel_pc;

    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) grant = prio;
        else if (bus.req1_valid)              grant = 1'b1;
        sel_op = grant ? bus.req1_op : bus.req0_op;
        sel_a  = grant ? bus.req1_a  : bus.req0_a;
        sel_b  = grant ? bus.req1_b  : bus.req0_b;
        sel_pc = grant ? bus.req1_pc : bus.req0_pc;
    end

    assign bus.req0_ready = (state == IDLE) && !grant && bus.req0_valid;
    assign bus.req1_ready = (state == IDLE) &&  grant && bus.req1_valid;
    assign accept         = bus.req0_ready || bus.req1_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            prio               <= 1'b0;
            owner              <= 1'b0;
            bus.alu_rs1        <= '0;
            bus.alu_rs2_or_imm <= '0;
            bus.alu_pc         <= '0;
            bus.alu_op_sel     <= '0;
            bus.rsp_data       <= '0;
            bus.rsp0_valid     <= 1'b0;
            bus.rsp1_valid     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    bus.alu_rs1        <= sel_a;
                    bus.alu_rs2_or_imm <= sel_b;
                    bus.alu_pc         <= sel_pc;
                    bus.alu_op_sel     <= sel_op;
                    owner              <= grant;
                    prio               <= ~grant;
                    state              <= ISSUE;
                end
                ISSUE: begin
                    bus.rsp_data   <= bus.alu_out;
                    bus.rsp0_valid <= !owner;
                    bus.rsp1_valid <= owner;
                    state          <= RESP;
                end
                RESP: if ((owner && bus.rsp1_ready) || (!owner && bus.rsp0_ready)) begin
                    bus.rsp0_valid <= 1'b0;
                    bus.rsp1_valid <= 1'b0;
                    state          <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SMOL_ALU_ARB_STATS_EN
    // Counters wrap naturally at 32 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stat_grant0   <= '0;
            bus.stat_grant1   <= '0;
            bus.stat_conflict <= '0;
        end else begin
            if (bus.req0_ready) bus.stat_grant0 <= bus.stat_grant0 + 32'd1;
            if (bus.req1_ready) bus.stat_grant1 <= bus.stat_grant1 + 32'd1;
            if (state == IDLE && bus.req0_valid && bus.req1_valid)
                bus.stat_conflict <= bus.stat_conflict + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_smol_alu_arbiter.sv
// tb/tb_smol_alu_arbiter.sv - directed vector bench for smol_alu_arbiter
module tb_smol_alu_arbiter;
    localparam int XLEN = 32;
    localparam int OPW  = 5;
    localparam int PCW  = 5;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    smol_alu_arbiter_if #(.XLEN(XLEN), .OPW(OPW), .PCW(PCW)) bus ();
    smol_alu_arbiter #(.XLEN(XLEN), .OPW(OPW), .PCW(PCW)) dut (.clk(clk), .rst(rst), .bus(bus));

    // Stand-in for the combinational smolALU, covering only the ops exercised here.
    always_comb begin
        bus.alu_out = '0;
        case (bus.alu_op_sel)
            5'd0:  bus.alu_out = bus.alu_rs1 + bus.alu_rs2_or_imm;
            5'd1:  bus.alu_out = bus.alu_rs1 - bus.alu_rs2_or_imm;
            5'd4:  bus.alu_out = bus.alu_rs1 | bus.alu_rs2_or_imm;
            5'd9:  bus.alu_out = {27'd0, bus.alu_pc} + bus.alu_rs2_or_imm;
            5'd14: bus.alu_out = (bus.alu_rs1 == bus.alu_rs2_or_imm) ?
                                 {27'd0, bus.alu_pc} + bus.alu_rs2_or_imm : '0;
            default: bus.alu_out = '0;
        endcase
    end

    typedef struct {
        logic        port;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  pc;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[8];
    int   total = 0;
    int   bad = 0;
    logic found;
    logic g;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0; bus.req0_pc = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0; bus.req1_pc = 0;
        bus.rsp0_ready = 0; bus.rsp1_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
    endtask

    // Called at a negedge with the arbiter idle; returns at a negedge, idle again.
    task automatic run_txn(input vec_t v);
        if (!v.port) begin
            bus.req0_valid = 1; bus.req0_op = v.op; bus.req0_a = v.a; bus.req0_b = v.b; bus.req0_pc = v.pc;
        end else begin
            bus.req1_valid = 1; bus.req1_op = v.op; bus.req1_a = v.a; bus.req1_b = v.b; bus.req1_pc = v.pc;
        end
        #1;
        check("vec_ready0", bus.req0_ready, !v.port);
        check("vec_ready1", bus.req1_ready, v.port);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        check("vec_issue_novalid", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        @(posedge clk);
        @(negedge clk);
        check("vec_rsp0_valid", bus.rsp0_valid, !v.port);
        check("vec_rsp1_valid", bus.rsp1_valid, v.port);
        check("vec_rsp_data", bus.rsp_data, v.exp);
        if (!v.port) bus.rsp0_ready = 1; else bus.rsp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp0_ready = 0;
        bus.rsp1_ready = 0;
        check("vec_rsp_done", {bus.rsp1_valid, bus.rsp0_valid}, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{port: 1'b0, op: 5'd0,  a: 32'd5,          b: 32'd7,    pc: 5'd0, exp: 32'd12};
        vecs[1] = '{port: 1'b0, op: 5'd1,  a: 32'd10,         b: 32'd3,    pc: 5'd0, exp: 32'd7};
        vecs[2] = '{port: 1'b1, op: 5'd4,  a: 32'hF0,         b: 32'h0F,   pc: 5'd0, exp: 32'hFF};
        vecs[3] = '{port: 1'b1, op: 5'd9,  a: 32'd0,          b: 32'd8,    pc: 5'd4, exp: 32'd12};
        vecs[4] = '{port: 1'b0, op: 5'd14, a: 32'd3,          b: 32'd3,    pc: 5'd2, exp: 32'd5};
        vecs[5] = '{port: 1'b0, op: 5'd14, a: 32'd3,          b: 32'd4,    pc: 5'd2, exp: 32'd0};
        vecs[6] = '{port: 1'b1, op: 5'd25, a: 32'd9,          b: 32'd9,    pc: 5'd1, exp: 32'd0};
        vecs[7] = '{port: 1'b1, op: 5'd0,  a: 32'hFFFF_FFFF,  b: 32'd1,    pc: 5'd0, exp: 32'd0};

        clear_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("rst_rsp0_valid", bus.rsp0_valid, 0);
        check("rst_rsp1_valid", bus.rsp1_valid, 0);
        check("rst_rsp_data", bus.rsp_data, 0);
        check("rst_alu_rs1", bus.alu_rs1, 0);
        check("rst_alu_rs2", bus.alu_rs2_or_imm, 0);
        check("rst_alu_op_pc", {bus.alu_op_sel, bus.alu_pc}, 0);
        check("rst_ready", {bus.req1_ready, bus.req0_ready}, 0);

        for (int i = 0; i < 8; i++) run_txn(vecs[i]);
        check("alu_hold_rs1", bus.alu_rs1, 32'hFFFF_FFFF);

        // Continuous contention: grants alternate starting at port 0.
        do_reset();
        bus.req0_valid = 1; bus.req0_op = 5'd1; bus.req0_a = 32'd10;  bus.req0_b = 32'd3;
        bus.req1_valid = 1; bus.req1_op = 5'd4; bus.req1_a = 32'hF0;  bus.req1_b = 32'h0F;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        for (int i = 0; i < 4; i++) begin
            found = 0;
            for (int c = 0; c < 10 && !found; c++) begin
                #1;
                if (bus.req0_ready || bus.req1_ready) found = 1;
                else begin @(posedge clk); @(negedge clk); end
            end
            check("cont_grant_seen", found, 1);
            check("cont_not_both", bus.req0_ready & bus.req1_ready, 0);
            g = bus.req1_ready;
            check("cont_grant_order", g, i % 2);
            @(posedge clk);
            @(negedge clk);
            if (i == 3) begin bus.req0_valid = 0; bus.req1_valid = 0; end
            found = 0;
            for (int c = 0; c < 5 && !found; c++) begin
                #1;
                if (bus.rsp0_valid || bus.rsp1_valid) found = 1;
                else begin @(posedge clk); @(negedge clk); end
            end
            check("cont_rsp_seen", found, 1);
            check("cont_rsp_port", {bus.rsp1_valid, bus.rsp0_valid}, (i % 2) ? 2 : 1);
            check("cont_rsp_data", bus.rsp_data, (i % 2) ? 32'hFF : 32'd7);
            @(posedge clk);
            @(negedge clk);
        end
        bus.rsp0_ready = 0;
        bus.rsp1_ready = 0;
`ifdef SMOL_ALU_ARB_STATS_EN
        check("stat_grant0", bus.stat_grant0, 2);
        check("stat_grant1", bus.stat_grant1, 2);
        check("stat_conflict", bus.stat_conflict, 4);
`endif

        // Backpressure on port 1 while port 0 waits.
        do_reset();
        bus.req1_valid = 1; bus.req1_op = 5'd9; bus.req1_a = 0; bus.req1_b = 32'd8; bus.req1_pc = 5'd4;
        #1;
        check("bp_accept1", bus.req1_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req1_valid = 0;
        bus.req0_valid = 1; bus.req0_op = 5'd0; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_pc = 0;
        @(posedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_rsp1_held", {bus.rsp1_valid, bus.rsp0_valid}, 2);
            check("bp_data_held", bus.rsp_data, 32'd12);
            check("bp_req0_blocked", bus.req0_ready, 0);
            @(posedge clk);
        end
        @(negedge clk);
        bus.rsp1_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp1_ready = 0;
        #1;
        check("bp_rsp1_cleared", bus.rsp1_valid, 0);
        check("bp_idle_req0", bus.req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req0_valid = 0;
        @(posedge clk);
        @(negedge clk);
        check("bp_rsp0_valid", bus.rsp0_valid, 1);
        check("bp_rsp0_data", bus.rsp_data, 32'd2);
        bus.rsp0_ready = 1;
        @(posedge clk);
        @(negedge clk);
        bus.rsp0_ready = 0;

        // Reset while in ISSUE drops the transaction and restores prio.
        do_reset();
        bus.req0_valid = 1; bus.req0_op = 5'd0; bus.req0_a = 32'd2; bus.req0_b = 32'd2;
        bus.req1_valid = 1; bus.req1_op = 5'd0; bus.req1_a = 32'd4; bus.req1_b = 32'd4;
        #1;
        check("ri_first_grant0", bus.req0_ready, 1);
        @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("ri_rsp_none", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        check("ri_regrant0", bus.req0_ready, 1);
        check("ri_no_grant1", bus.req1_ready, 0);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check("ri_rsp_never", {bus.rsp1_valid, bus.rsp0_valid}, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/smol_alu_arbiter.md
Name: smol_alu_arbiter

Overview:
- Shares the single combinational smolALU between two requesters: execute stage (port 0) and the branch/address unit (port 1).
- Round-robin grant with per-port valid/ready request and response handshakes.
- Registers operands toward the ALU and registers the ALU result back to the owner. One transaction in flight.

Parameters:
- XLEN, 32, operand/result width
- OPW, 5, op_sel width
- PCW, 5, pc width fed to ALU

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req0_valid / req1_valid  in  1  request present
- req0_ready / req1_ready  out  1  request accepted this cycle when valid&ready
- req0_op / req1_op  in  OPW  ALU op_sel code
- req0_a / req1_a  in  XLEN  rs1 operand
- req0_b / req1_b  in  XLEN  rs2_or_imm operand
- req0_pc / req1_pc  in  PCW  pc operand
- rsp0_valid / rsp1_valid  out  1  result available for that port
- rsp0_ready / rsp1_ready  in  1  owner consumes result
- rsp_data  out  XLEN  result, shared by both ports, qualified by rspN_valid
- alu_rs1  out  XLEN  to ALU rs1
- alu_rs2_or_imm  out  XLEN  to ALU rs2_or_imm
- alu_pc  out  PCW  to ALU pc
- alu_op_sel  out  OPW  to ALU op_sel
- alu_out  in  XLEN  from ALU

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, prio=0, owner=0. alu_rs1, alu_rs2_or_imm, alu_pc, alu_op_sel and rsp_data =0. rspN_valid=0.
- FSM states: IDLE, ISSUE, RESP.
- IDLE grant (combinational):
  - Both valid: grant = prio.
  - One valid: grant = that port.
  - reqN_ready = (state==IDLE) & grant==N & reqN_valid. Never both high.
  - reqN_ready is 0 in ISSUE and RESP.
- Accept (IDLE, valid&ready on port g):
  - Register op/a/b/pc into alu_* outputs.
  - owner<=g; prio<=~g; next state ISSUE.
  - prio does not change when no request is accepted.
- ISSUE: rsp_data<=alu_out, with alu_* stable from the registers. Next state RESP.
- RESP: rsp[owner]_valid=1, other rspN_valid=0.
  - Hold rsp_data and valid until rsp[owner]_ready. Then go to IDLE.
  - rspN_ready is ignored for the non-owner and outside RESP.
- Latency and throughput:
  - Accept at edge N → rsp valid during cycle N+2.
  - No new accept in the cycle rsp handshake completes. Best-case throughput is one op per 3 cycles.
- alu_* hold the last accepted values outside ISSUE; they are not cleared.
- Op codes are passed through unchecked. Undefined codes (>19) yield ALU result 0, returned normally.
- Fairness: under continuous contention grants strictly alternate 0,1,0,1. A single active port is granted every transaction.
- Request inputs need not be held after acceptance. Requesters must hold op/a/b/pc stable while valid&!ready.
- Reset mid-transaction: transaction dropped. Next cycle state=IDLE, rspN_valid=0, prio=0. No response is ever produced for it.
- rsp_data is valid only while rspN_valid=1.

Optional Feature:
- Macro: SMOL_ALU_ARB_STATS_EN.
- Defined: adds outputs stat_grant0, stat_grant1 and stat_conflict (each 32 bits).
  - stat_grantN increments on each accept from port N.
  - stat_conflict increments on each IDLE cycle with both req valid.
  - All counters wrap 0xFFFFFFFF→0 and reset to 0.
- Undefined: those ports and counters are absent. All other behaviour is identical.

Test Plan:
- Basic add: reset, req0 op=0 a=5 b=7 pc=0 → req0_ready at accept; rsp0_valid 2 cycles later with rsp_data=12, rsp1_valid=0.
- Contention: both valid continuously, port0 op=1 a=10 b=3, port1 op=4 a=0xF0 b=0x0F, rspN_ready=1.
  - Grants alternate 0,1,0,1 starting at 0.
  - Responses are 7 (port 0) and 0xFF (port 1) on the correct rspN_valid.
- Backpressure: req1 op=9 pc=4 b=8, rsp1_ready=0 for 5 cycles.
  - rsp1_valid and rsp_data=12 are held stable all 5 cycles; req0_ready stays 0 throughout.
  - Returns to IDLE the cycle after rsp1_ready=1.
- Branch op: req0 op=14 a=3 b=3 pc=2 → rsp_data=5. Then a=3 b=4 → rsp_data=0.
- Reset in ISSUE: rst asserted in the cycle after accept → next cycle state IDLE, no rspN_valid ever asserted, next contention grants port 0.
- Stats (SMOL_ALU_ARB_STATS_EN): 3 contended transactions → stat_grant0=2, stat_grant1=1; stat_conflict counts contended IDLE cycles. Preloading a counter to 0xFFFFFFFF wraps it to 0.
